decode_pipe: RTL

//   Parametrised decode stage with its own ID/EX register. Takes the IF/ID instruction,

---
 rtl/decode_pkg.sv | 67 ++++++
 rtl/decode_pipe_if.sv | 43 ++++
 rtl/decode_regfile.sv | 47 ++++
 rtl/decode_pipe.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, control-word layout and decode helpers for decode_pipe
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Control word layout: {regDst,branch,memRead,memToReg,aluOp[1:0],memWrite,aluSrc,regWrite}
  localparam int CTRL_W         = 9;
  localparam int CTRL_REG_DST   = 8;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_OP_HI = 4;
  localparam int CTRL_ALU_OP_LO = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_SRC   = 1;
  localparam int CTRL_REG_WRITE = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Unknown opcodes decode to an all-zero control word (NOP)
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c[CTRL_REG_DST]   = 1'b1;
        c[CTRL_ALU_OP_HI] = 1'b1;
        c[CTRL_REG_WRITE] = 1'b1;
      end
      OP_LW: begin
        c[CTRL_MEM_READ]   = 1'b1;
        c[CTRL_MEM_TO_REG] = 1'b1;
        c[CTRL_ALU_SRC]    = 1'b1;
        c[CTRL_REG_WRITE]  = 1'b1;
      end
      OP_SW: begin
        c[CTRL_MEM_WRITE] = 1'b1;
        c[CTRL_ALU_SRC]   = 1'b1;
      end
      OP_BEQ: begin
        c[CTRL_BRANCH]    = 1'b1;
        c[CTRL_ALU_OP_LO] = 1'b1;
      end
      OP_ADDI: begin
        c[CTRL_ALU_SRC]   = 1'b1;
        c[CTRL_REG_WRITE] = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a source operand, not a destination
  function automatic logic usesRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// rtl/decode_pipe_if.sv - IF/ID, write-back and ID/EX signal bundle for decode_pipe
interface decode_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 32
);
  import decode_pkg::*;

  localparam int REG_AW = $clog2(NUM_REGS);

  logic              ifid_valid;
  logic [31:0]       ifid_instr;
  logic [PC_W-1:0]   ifid_pc;
  logic              flush;
  logic              ex_hold;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              stall;
  logic              idex_valid;
  ctrl_t             idex_ctrl;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] idex_imm;
  logic [REG_AW-1:0] idex_rs;
  logic [REG_AW-1:0] idex_rt;
  logic [REG_AW-1:0] idex_rd;
  logic [PC_W-1:0]   idex_pc;

  modport master (
    output ifid_valid, ifid_instr, ifid_pc, flush, ex_hold, wb_we, wb_rd, wb_data,
    input  stall, idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
           idex_rs, idex_rt, idex_rd, idex_pc
  );

  modport slave (
    input  ifid_valid, ifid_instr, ifid_pc, flush, ex_hold, wb_we, wb_rd, wb_data,
    output stall, idex_valid, idex_ctrl, idex_rs_data, idex_rt_data, idex_imm,
           idex_rs, idex_rt, idex_rd, idex_pc
  );

endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2R1W register file with hard-wired zero register; DECODE_WB_BYPASS_EN enables write-first reads
module decode_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [REG_AW-1:0] rAddrA,
  input  logic [REG_AW-1:0] rAddrB,
  output logic [DATA_W-1:0] rDataA,
  output logic [DATA_W-1:0] rDataB
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update; register 0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wAddr != '0)) begin
      regs[wAddr] <= wData;
    end
  end

  // Read port A, optionally forwarding the write in flight
  always_comb begin
    rDataA = regs[rAddrA];
`ifdef DECODE_WB_BYPASS_EN
    if (we && (wAddr == rAddrA)) rDataA = wData;
`endif
    if (rAddrA == '0) rDataA = '0;
  end

  // Read port B, same rules as port A
  always_comb begin
    rDataB = regs[rAddrB];
`ifdef DECODE_WB_BYPASS_EN
    if (we && (wAddr == rAddrB)) rDataB = wData;
`endif
    if (rAddrB == '0) rDataB = '0;
  end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage with ID/EX register, load-use stall FSM, flush and EX hold; DECODE_WB_BYPASS_EN selects regfile bypass
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_REGS       = 32,
  parameter int PC_W           = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_pipe_if.slave  bus
);

  localparam int REG_AW = $clog2(NUM_REGS);
  // Bubbles still owed after the one inserted in the hazard cycle itself
  localparam logic [2:0] STALL_EXTRA = 3'(LOAD_USE_STALL - 1);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rsIdx, rtIdx, rdField, rdSel;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] rsData, rtData, imm;
  logic              hazard;

  state_t            state, stateNext;
  logic [2:0]        cnt, cntNext;
  logic              idexLoad, idexBubble, stallInt;

  logic              idexValid;
  ctrl_t             idexCtrl;
  logic [DATA_W-1:0] idexRsData, idexRtData, idexImm;
  logic [REG_AW-1:0] idexRs, idexRt, idexRd;
  logic [PC_W-1:0]   idexPc;

  assign opcode  = bus.ifid_instr[31:26];
  assign rsIdx   = bus.ifid_instr[21 +: REG_AW];
  assign rtIdx   = bus.ifid_instr[16 +: REG_AW];
  assign rdField = bus.ifid_instr[11 +: REG_AW];
  assign ctrl    = decode_ctrl(opcode);
  assign rdSel   = ctrl[CTRL_REG_DST] ? rdField : rtIdx;
  assign imm     = DATA_W'($signed(bus.ifid_instr[15:0]));

  decode_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.wb_we),
    .wAddr  (bus.wb_rd),
    .wData  (bus.wb_data),
    .rAddrA (rsIdx),
    .rAddrB (rtIdx),
    .rDataA (rsData),
    .rDataB (rtData)
  );

  // A load in ID/EX whose destination is read by the instruction in decode
  assign hazard = idexValid && idexCtrl[CTRL_MEM_READ] && (idexRt != '0) && bus.ifid_valid &&
                  ((idexRt == rsIdx) || ((idexRt == rtIdx) && usesRt(opcode)));

  // FSM state and bubble counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, ID/EX update selection and upstream stall
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    idexLoad   = 1'b0;
    idexBubble = 1'b0;
    stallInt   = 1'b0;
    if (bus.flush) begin
      idexBubble = 1'b1;
      stateNext  = ST_RUN;
      cntNext    = '0;
    end else if (bus.ex_hold) begin
      stallInt = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            idexBubble = 1'b1;
            stallInt   = 1'b1;
            if (STALL_EXTRA != 3'd0) begin
              stateNext = ST_STALL;
              cntNext   = STALL_EXTRA;
            end
          end else if (bus.ifid_valid) begin
            idexLoad = 1'b1;
          end else begin
            idexBubble = 1'b1;
          end
        end
        ST_STALL: begin
          idexBubble = 1'b1;
          stallInt   = 1'b1;
          cntNext    = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            stateNext = ST_RUN;
            cntNext   = '0;
          end
        end
        default: begin
          stateNext = ST_RUN;
          cntNext   = '0;
        end
      endcase
    end
  end

  assign bus.stall = rst_n & stallInt;

  // ID/EX pipeline register: load, clear to a bubble, or hold
  always_ff @(posedge clk) begin
    if (!rst_n || idexBubble) begin
      idexValid  <= 1'b0;
      idexCtrl   <= '0;
      idexRsData <= '0;
      idexRtData <= '0;
      idexImm    <= '0;
      idexRs     <= '0;
      idexRt     <= '0;
      idexRd     <= '0;
      idexPc     <= '0;
    end else if (idexLoad) begin
      idexValid  <= 1'b1;
      idexCtrl   <= ctrl;
      idexRsData <= rsData;
      idexRtData <= rtData;
      idexImm    <= imm;
      idexRs     <= rsIdx;
      idexRt     <= rtIdx;
      idexRd     <= rdSel;
      idexPc     <= bus.ifid_pc;
    end
  end

  assign bus.idex_valid   = idexValid;
  assign bus.idex_ctrl    = idexCtrl;
  assign bus.idex_rs_data = idexRsData;
  assign bus.idex_rt_data = idexRtData;
  assign bus.idex_imm     = idexImm;
  assign bus.idex_rs      = idexRs;
  assign bus.idex_rt      = idexRt;
  assign bus.idex_rd      = idexRd;
  assign bus.idex_pc      = idexPc;

endmodule
